// File: rtl/sequential_divider_if.sv
// Purpose: bundles the divider request operands and result signals into one port.
// Latency: n/a (wires only).
// Backpressure: none; the requester sees busy/done and must not expect start to be taken outside IDLE.
// Ports:
//   master - drives start/dividend/divisor, receives busy/done/quotient/remainder/div_by_zero
//   slave  - the divider side of the same signals
interface sequential_divider_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/sequential_divider.sv
// Purpose: unsigned restoring divider, one quotient bit per clock (IDLE -> CALC -> DONE -> IDLE).
// Latency: WIDTH edges from start accept to done; next start is taken once back in IDLE.
// Backpressure: start is only sampled in IDLE and ignored otherwise; busy/done show the state.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous, active-high; clears state and all results
//   bus   - sequential_divider_if.slave: start/dividend/divisor in,
//           busy/done/quotient/remainder/div_by_zero out
// Build option: SEQDIV_EARLY_ZERO_EN - a zero divisor skips CALC and reports in DONE right after accept.
module sequential_divider #(
  parameter int WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  sequential_divider_if.slave   bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef SEQDIV_EARLY_ZERO_EN
  localparam bit EARLY_ZERO = 1'b1;
`else
  localparam bit EARLY_ZERO = 1'b0;
`endif

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;         // dividend shift register, MSB feeds the remainder
  logic [WIDTH-1:0] dvs_q, dvs_d;         // captured divisor
  logic [WIDTH-1:0] part_q, part_d;       // partial remainder after restore
  logic [WIDTH-1:0] quo_q, quo_d;         // quotient shift register
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   part_shift;
  logic             fits;
  logic [WIDTH-1:0] part_next;
  logic [WIDTH-1:0] quo_next;

  always_comb begin
    state_d     = state_q;
    dsr_d       = dsr_q;
    dvs_d       = dvs_q;
    part_d      = part_q;
    quo_d       = quo_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;

    // One restoring step. The shifted remainder needs WIDTH+1 bits, but after
    // the conditional subtract it is always below the divisor (or, for a zero
    // divisor, just the top bits of the dividend), so WIDTH bits hold it.
    part_shift = {part_q, dsr_q[WIDTH-1]};
    fits       = (part_shift >= {1'b0, dvs_q});
    part_next  = fits ? WIDTH'(part_shift - {1'b0, dvs_q}) : part_shift[WIDTH-1:0];
    quo_next   = {quo_q[WIDTH-2:0], fits};

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          dsr_d   = bus.dividend;
          dvs_d   = bus.divisor;
          part_d  = '0;
          quo_d   = '0;
          cnt_d   = '0;
          state_d = S_CALC;
          if (EARLY_ZERO && (bus.divisor == '0)) begin
            // Same answer the full loop would give, delivered without iterating.
            state_d     = S_DONE;
            quotient_d  = '1;
            remainder_d = bus.dividend;
            dbz_d       = 1'b1;
          end
        end
      end
      S_CALC: begin
        dsr_d  = {dsr_q[WIDTH-2:0], 1'b0};
        part_d = part_next;
        quo_d  = quo_next;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          // Results are taken from the final step directly so they appear
          // on the same edge that enters DONE.
          state_d     = S_DONE;
          quotient_d  = quo_next;
          remainder_d = part_next;
          dbz_d       = (dvs_q == '0);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      dsr_q       <= '0;
      dvs_q       <= '0;
      part_q      <= '0;
      quo_q       <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      dsr_q       <= dsr_d;
      dvs_q       <= dvs_d;
      part_q      <= part_d;
      quo_q       <= quo_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign bus.busy        = (state_q == S_CALC);
  assign bus.done        = (state_q == S_DONE);
  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.div_by_zero = dbz_q;

endmodule
